// File: rtl/adc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_pkg                                                              |
// | Shared converter/averager types: sample word and averager states.   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package adc_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } avg_state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/sample_ring.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_ring                                                          |
// | DEPTH-entry sample history with wrapping write pointer.              |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module sample_ring #(
    parameter int LOG2_DEPTH = 3,
    parameter int SAMPLE_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [SAMPLE_W-1:0]   wr_data,
    output logic [SAMPLE_W-1:0]   oldest,
    output logic [LOG2_DEPTH-1:0] wr_ptr
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [SAMPLE_W-1:0]   ring_q [DEPTH];
    logic [SAMPLE_W-1:0]   ring_d [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH-1:0] wr_ptr_d;

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            ring_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so natural overflow is the wrap.
            wr_ptr_d         = wr_ptr_q + LOG2_DEPTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring_q   <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Cleared entries read as zero, so during fill the evicted value is 0.
    assign oldest = ring_q[wr_ptr_q];
    assign wr_ptr = wr_ptr_q;

endmodule : sample_ring
`default_nettype wire

// File: rtl/adc_moving_average.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_moving_average                                                   |
// | Boxcar mean over the last 2^LOG2_DEPTH samples, valid/ready output. |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module adc_moving_average #(
    parameter int LOG2_DEPTH = 3,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                flush,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                overrun,
    input  logic                clear_overrun
);

    import adc_pkg::*;

    localparam int                    DEPTH      = 1 << LOG2_DEPTH;
    localparam int                    SUM_W      = SAMPLE_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] C_LAST_PTR = LOG2_DEPTH'(DEPTH - 1);

    logic [SUM_W-1:0]      sum_q, sum_d, sum_next;
    avg_state_t            state_q, state_d;
    logic                  avg_valid_q, avg_valid_d;
    logic [SAMPLE_W-1:0]   avg_out_q, avg_out_d;
    logic                  overrun_q, overrun_d;
    logic [SAMPLE_W-1:0]   oldest;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic                  accept;
    logic                  load;
    logic                  lost;

    sample_ring #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .SAMPLE_W   (SAMPLE_W)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .wr_en   (accept),
        .wr_data (sample_in),
        .oldest  (oldest),
        .wr_ptr  (wr_ptr)
    );

    always_comb begin
        accept   = sample_valid & ~flush;
        sum_next = sum_q + SUM_W'(sample_in) - SUM_W'(oldest);
        // Pointer and fill count advance together from zero, so in FILL the
        // pointer itself tells when the window becomes full.
        load     = accept & ((state_q == RUN) | (wr_ptr == C_LAST_PTR));
        lost     = load & avg_valid_q & ~avg_ready;

        sum_d       = sum_q;
        state_d     = state_q;
        avg_valid_d = avg_valid_q;
        avg_out_d   = avg_out_q;

        if (flush) begin
            sum_d       = '0;
            state_d     = FILL;
            avg_valid_d = 1'b0;
        end else begin
            if (accept) begin
                sum_d = sum_next;
            end
            if (load) begin
                state_d     = RUN;
                avg_valid_d = 1'b1;
                avg_out_d   = sum_next[SUM_W-1:LOG2_DEPTH];
            end else if (avg_valid_q && avg_ready) begin
                avg_valid_d = 1'b0;
            end
        end

        overrun_d = lost | (overrun_q & ~clear_overrun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            state_q     <= FILL;
            avg_valid_q <= 1'b0;
            avg_out_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            state_q     <= state_d;
            avg_valid_q <= avg_valid_d;
            avg_out_q   <= avg_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign avg_valid = avg_valid_q;
    assign avg_out   = avg_out_q;
    assign overrun   = overrun_q;

endmodule : adc_moving_average
`default_nettype wire

// File: tb/tb_adc_moving_average.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_adc_moving_average                                                |
// | Vector table plus scoreboarded corner sequences, DEPTH=4.            |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_adc_moving_average;

    import adc_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    sample_valid;
    sample_t sample_in;
    logic    flush;
    logic    avg_valid;
    logic    avg_ready;
    sample_t avg_out;
    logic    overrun;
    logic    clear_overrun;

    always #5 clk = ~clk;

    adc_moving_average #(
        .LOG2_DEPTH (2),
        .SAMPLE_W   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .flush         (flush),
        .avg_valid     (avg_valid),
        .avg_ready     (avg_ready),
        .avg_out       (avg_out),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    int total = 0;
    int bad   = 0;

    int          win[$];
    logic [15:0] sb[$];
    bit          mv;
    bit          mov;

    typedef struct {
        bit          sv;
        bit          fl;
        logic [15:0] d;
        bit          ev;
        logic [15:0] eo;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit sv, input bit fl, input logic [15:0] d,
                       input bit ev, input logic [15:0] eo);
        vec_t v;
        v.sv = sv; v.fl = fl; v.d = d; v.ev = ev; v.eo = eo;
        vt.push_back(v);
    endtask

    task automatic model_reset();
        win.delete();
        sb.delete();
        mv  = 1'b0;
        mov = 1'b0;
    endtask

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model_edge(input bit sv, input bit fl, input logic [15:0] d,
                              input bit rdy, input bit clr);
        int s;
        bit set;
        set = 1'b0;
        if (mv && rdy) mv = 1'b0;
        if (fl) begin
            win.delete();
            sb.delete();
            mv = 1'b0;
        end else if (sv) begin
            win.push_back(int'(d));
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4) begin
                s = 0;
                foreach (win[i]) s += win[i];
                if (mv) begin
                    set = 1'b1;
                    void'(sb.pop_back());
                end
                sb.push_back(16'(s >> 2));
                mv = 1'b1;
            end
        end
        mov = set | (mov & !clr);
    endtask

    // Entered and left at posedge+1.
    task automatic cyc(input bit sv, input bit fl, input logic [15:0] d,
                       input bit rdy, input bit clr = 1'b0);
        sample_valid  = sv;
        flush         = fl;
        sample_in     = d;
        avg_ready     = rdy;
        clear_overrun = clr;
        @(negedge clk);
        if (avg_valid && avg_ready) begin
            if (sb.size() == 0) check("sb_unexpected_result", 1, 0);
            else                check("sb_result", int'(avg_out), int'(sb.pop_front()));
        end
        model_edge(sv, fl, d, rdy, clr);
        @(posedge clk);
        #1;
        sample_valid  = 1'b0;
        flush         = 1'b0;
        clear_overrun = 1'b0;
        check("model_valid", int'(avg_valid), int'(mv));
        check("model_overrun", int'(overrun), int'(mov));
        if (mv) check("model_out", int'(avg_out), int'(sb[$]));
    endtask

    initial begin
        reset         = 1'b1;
        sample_valid  = 1'b0;
        sample_in     = '0;
        flush         = 1'b0;
        avg_ready     = 1'b1;
        clear_overrun = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(avg_valid), 0);
        check("reset_out", int'(avg_out), 0);
        check("reset_overrun", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Warm-up, sliding, truncation and full-scale with ready held high.
        add(1, 0, 16'h0100, 0, 16'h0000);
        add(1, 0, 16'h0200, 0, 16'h0000);
        add(1, 0, 16'h0300, 0, 16'h0000);
        add(1, 0, 16'h0400, 1, 16'h0280);
        add(1, 0, 16'h0800, 1, 16'h0440);
        add(1, 0, 16'h0800, 1, 16'h05C0);
        add(0, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0001, 0, 16'h0000);
        add(1, 0, 16'h0001, 0, 16'h0000);
        add(1, 0, 16'h0001, 0, 16'h0000);
        add(1, 0, 16'h0002, 1, 16'h0001);
        add(1, 0, 16'hFFFF, 1, 16'h4000);
        add(1, 0, 16'hFFFF, 1, 16'h8000);
        add(1, 0, 16'hFFFF, 1, 16'hBFFF);
        add(1, 0, 16'hFFFF, 1, 16'hFFFF);
        add(0, 0, 16'h0000, 0, 16'h0000);

        foreach (vt[i]) begin
            cyc(vt[i].sv, vt[i].fl, vt[i].d, 1'b1);
            check($sformatf("vec%0d_valid", i), int'(avg_valid), int'(vt[i].ev));
            if (vt[i].ev) check($sformatf("vec%0d_out", i), int'(avg_out), int'(vt[i].eo));
        end

        // Backpressure: second result overwrites the first.
        cyc(1, 0, 16'h0004, 0);
        check("bp_first_valid", int'(avg_valid), 1);
        cyc(1, 0, 16'h0008, 0);
        check("bp_overrun", int'(overrun), 1);
        check("bp_out", int'(avg_out), 16'h8002);
        cyc(0, 0, 16'h0000, 1);
        check("bp_drained", int'(avg_valid), 0);
        cyc(0, 0, 16'h0000, 1, 1);
        check("clear_overrun", int'(overrun), 0);

        // Consume and reload on the same edge.
        cyc(1, 0, 16'h000C, 0);
        cyc(1, 0, 16'h0010, 1);
        check("same_edge_valid", int'(avg_valid), 1);
        check("same_edge_overrun", int'(overrun), 0);
        check("same_edge_out", int'(avg_out), 16'h000A);

        // New overrun event beats clear_overrun in the same cycle.
        cyc(1, 0, 16'h0014, 0);
        cyc(1, 0, 16'h0018, 0, 1);
        check("set_wins", int'(overrun), 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("set_wins_cleared", int'(overrun), 0);

        // Flush concurrent with a sample drops it and restarts the fill.
        for (int i = 0; i < 6; i++) cyc(1, 0, 16'($urandom_range(0, 16'hFFFF)), 1);
        cyc(1, 1, 16'h1234, 1);
        check("flush_valid", int'(avg_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'($urandom_range(0, 16'hFFFF)), 1);
            check("flush_refill", int'(avg_valid), 0);
        end
        cyc(1, 0, 16'($urandom_range(0, 16'hFFFF)), 1);
        check("flush_first_result", int'(avg_valid), 1);

        // Asynchronous reset mid-window with a pending result and overrun.
        for (int i = 0; i < 6; i++) cyc(1, 0, 16'($urandom_range(0, 16'hFFFF)), 0);
        check("pre_reset_overrun", int'(overrun), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", int'(avg_valid), 0);
        check("async_reset_out", int'(avg_out), 0);
        check("async_reset_overrun", int'(overrun), 0);
        sample_valid = 1'b1;
        sample_in    = 16'hAAAA;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'h0010 * 16'(i + 1), 1);
            check("reset_refill", int'(avg_valid), 0);
        end
        cyc(1, 0, 16'h0040, 1);
        check("reset_first_valid", int'(avg_valid), 1);
        check("reset_first_out", int'(avg_out), 16'h0028);
        cyc(0, 0, 16'h0000, 1);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adc_moving_average
`default_nettype wire
